// File: rtl/core_sequencer_if.sv
// Handshake bundle between core_sequencer and the ROM/decoder/branch/data-memory side.
// master = control/memory side driving requests, slave = the sequencer.
interface core_sequencer_if #(
  parameter int PW = 8,
  parameter int CW = 16
);
  logic          run;
  logic          branch_en;
  logic [PW-1:0] branch_target;
  logic          mem_req;
  logic          mem_ack;
  logic [PW-1:0] prog_ctr;
  logic          fetch;
  logic          exec_en;
  logic          busy;
  logic          done;
  logic          fault;
  logic [CW-1:0] cycle_cnt;

  modport master (
    output run, branch_en, branch_target, mem_req, mem_ack,
    input  prog_ctr, fetch, exec_en, busy, done, fault, cycle_cnt
  );

  modport slave (
    input  run, branch_en, branch_target, mem_req, mem_ack,
    output prog_ctr, fetch, exec_en, busy, done, fault, cycle_cnt
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle program sequencer: PC, FETCH/EXEC/WAIT_MEM control, mem-stall timeout, cycle counter.
// Optional macro PC_REL_BRANCH_EN: branch_target is a signed PC-relative offset instead of absolute.
module core_sequencer #(
  parameter int PW         = 8,
  parameter int DONE_ADDR  = 128,
  parameter int WAIT_LIMIT = 15,
  parameter int CW         = 16
) (
  input  logic             clk,
  input  logic             reset,
  core_sequencer_if.slave  bus
);
  localparam int WW = $clog2(WAIT_LIMIT + 1) + 1;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WAIT_MEM, HALT} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;
  logic [PW-1:0] br_pc, next_pc;
  logic          commit;
  logic          busy_w;

  always_comb begin
`ifdef PC_REL_BRANCH_EN
    br_pc = pc_q + bus.branch_target;
`else
    br_pc = bus.branch_target;
`endif
    next_pc = bus.branch_en ? br_pc : pc_q + PW'(1);
    busy_w  = (state_q == FETCH) || (state_q == EXEC) || (state_q == WAIT_MEM);

    state_d = state_q;
    pc_d    = pc_q;
    wcnt_d  = wcnt_q;
    done_d  = done_q;
    fault_d = fault_q;
    commit  = 1'b0;

    case (state_q)
      IDLE:  if (bus.run) state_d = FETCH;
      FETCH: state_d = EXEC;
      EXEC: begin
        if (bus.mem_req && !bus.mem_ack) begin
          state_d = WAIT_MEM;
          wcnt_d  = WW'(1);
        end else begin
          commit = 1'b1;
        end
      end
      WAIT_MEM: begin
        // The request was already qualified in EXEC, so only the ack matters here.
        if (bus.mem_ack) begin
          commit = 1'b1;
        end else if (wcnt_q + WW'(1) >= WW'(WAIT_LIMIT)) begin
          state_d = HALT;
          fault_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    if (commit) begin
      pc_d = next_pc;
      if (next_pc == PW'(DONE_ADDR)) begin
        state_d = HALT;
        done_d  = 1'b1;
      end else begin
        state_d = FETCH;
      end
    end

    cnt_d = (busy_w && cnt_q != '1) ? cnt_q + CW'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  // exec_en must fire in the ack cycle itself, so it is the only combinational output.
  assign bus.exec_en   = commit & ~reset;
  assign bus.prog_ctr  = pc_q;
  assign bus.fetch     = (state_q == FETCH);
  assign bus.busy      = busy_w;
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;
  assign bus.cycle_cnt = cnt_q;
endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: table-driven program steps with a commit scoreboard, plus
// hand-written reset/timeout/halt sequences; a second instance covers DONE_ADDR=200, CW=4.
module tb_core_sequencer;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  core_sequencer_if #(.PW(8), .CW(16)) if0 ();
  core_sequencer_if #(.PW(8), .CW(4))  if1 ();

  core_sequencer #(.PW(8), .DONE_ADDR(128), .WAIT_LIMIT(15), .CW(16)) dut0 (
    .clk(clk), .reset(rst), .bus(if0.slave));
  core_sequencer #(.PW(8), .DONE_ADDR(200), .WAIT_LIMIT(15), .CW(4)) dut1 (
    .clk(clk), .reset(rst), .bus(if1.slave));

  assign if1.run           = if0.run;
  assign if1.branch_en     = if0.branch_en;
  assign if1.branch_target = if0.branch_target;
  assign if1.mem_req       = if0.mem_req;
  assign if1.mem_ack       = if0.mem_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cur;
    logic [7:0] nxt;
  } exp_t;

  typedef struct {
    logic       br;
    logic [7:0] tgt;
    logic       mreq;
    int         stalls;
    logic       stray;
    logic [7:0] nxt;
  } vec_t;

  exp_t       scb[$];
  logic       pend = 1'b0;
  logic [7:0] pend_pc = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Commit monitor: every exec_en must match a queued expectation, and the PC must follow.
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      chk("pc_after_commit", 32'(if0.prog_ctr), 32'(pend_pc));
      pend = 1'b0;
    end
    if (if0.exec_en === 1'b1) begin
      if (scb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_exec_en: got 1 expected 0 at %0t", $time);
      end else begin
        e = scb.pop_front();
        chk("pc_at_commit", 32'(if0.prog_ctr), 32'(e.cur));
        pend    = 1'b1;
        pend_pc = e.nxt;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    if0.run = 1'b0; if0.branch_en = 1'b0; if0.branch_target = 8'h00;
    if0.mem_req = 1'b0; if0.mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_in();
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic start();
    if0.run = 1'b1;
    cyc();
    if0.run = 1'b0;
  endtask

  // Entry: just after the edge that put the DUT into FETCH.
  task automatic do_instr(input vec_t v, input logic [7:0] cur);
    exp_t e;
    e.cur = cur;
    e.nxt = v.nxt;
    scb.push_back(e);
    if0.branch_en = v.stray; if0.branch_target = 8'h77;
    if0.mem_req = 1'b0; if0.mem_ack = v.stray;
    @(negedge clk);
    chk("fetch_high", 32'(if0.fetch), 32'd1);
    chk("fetch_no_exec", 32'(if0.exec_en), 32'd0);
    cyc();
    if0.branch_en = v.br; if0.branch_target = v.tgt; if0.mem_req = v.mreq;
    if0.mem_ack = v.stray || (v.mreq && v.stalls == 0);
    @(negedge clk);
    chk("exec_commit", 32'(if0.exec_en), 32'(v.stalls == 0));
    for (int i = 1; i <= v.stalls; i++) begin
      cyc();
      if0.mem_ack = (i == v.stalls);
      @(negedge clk);
      chk("wait_commit", 32'(if0.exec_en), 32'(i == v.stalls));
      chk("wait_busy", 32'(if0.busy), 32'd1);
    end
    cyc();
    clr_in();
    chk("dut1_pc", 32'(if1.prog_ctr), 32'(v.nxt));
    chk("next_fetch", 32'(if0.fetch), 32'(v.nxt != 8'h80));
    chk("next_done", 32'(if0.done), 32'(v.nxt == 8'h80));
  endtask

  vec_t       tab[14];
  vec_t       v;
  logic [7:0] pc;

  initial begin
    for (int i = 0; i < 14; i++) tab[i] = '{br:1'b0, tgt:8'h00, mreq:1'b0, stalls:0, stray:1'b0, nxt:8'h00};
    for (int i = 0; i < 5; i++) tab[i].nxt = 8'(i + 1);
`ifdef PC_REL_BRANCH_EN
    tab[5]  = '{br:1'b1, tgt:8'hFE, mreq:1'b0, stalls:0, stray:1'b0, nxt:8'h03};
    tab[6]  = '{br:1'b1, tgt:8'h07, mreq:1'b0, stalls:0, stray:1'b0, nxt:8'h0A};
    tab[10] = '{br:1'b1, tgt:8'hF2, mreq:1'b1, stalls:1, stray:1'b0, nxt:8'hFF};
    tab[13] = '{br:1'b1, tgt:8'h7F, mreq:1'b0, stalls:0, stray:1'b0, nxt:8'h80};
`else
    tab[5]  = '{br:1'b1, tgt:8'h40, mreq:1'b0, stalls:0, stray:1'b0, nxt:8'h40};
    tab[6]  = '{br:1'b1, tgt:8'h0A, mreq:1'b0, stalls:0, stray:1'b0, nxt:8'h0A};
    tab[10] = '{br:1'b1, tgt:8'hFF, mreq:1'b1, stalls:1, stray:1'b0, nxt:8'hFF};
    tab[13] = '{br:1'b1, tgt:8'h80, mreq:1'b0, stalls:0, stray:1'b0, nxt:8'h80};
`endif
    tab[7]  = '{br:1'b0, tgt:8'h00, mreq:1'b1, stalls:3, stray:1'b0, nxt:8'h0B};
    tab[8]  = '{br:1'b0, tgt:8'h00, mreq:1'b1, stalls:0, stray:1'b0, nxt:8'h0C};
    tab[9]  = '{br:1'b0, tgt:8'h00, mreq:1'b0, stalls:0, stray:1'b1, nxt:8'h0D};
    tab[11] = '{br:1'b0, tgt:8'h00, mreq:1'b0, stalls:0, stray:1'b0, nxt:8'h00};
    tab[12] = '{br:1'b0, tgt:8'h00, mreq:1'b0, stalls:0, stray:1'b0, nxt:8'h01};

    // reset state and idle hold
    do_reset();
    chk("rst_pc", 32'(if0.prog_ctr), 32'd0);
    chk("rst_busy", 32'(if0.busy), 32'd0);
    chk("rst_done", 32'(if0.done), 32'd0);
    chk("rst_fault", 32'(if0.fault), 32'd0);
    chk("rst_cnt", 32'(if0.cycle_cnt), 32'd0);
    cyc(); cyc(); cyc();
    chk("idle_hold", 32'(if0.busy), 32'd0);

    // straight-line run to DONE_ADDR
    start();
    for (int i = 0; i < 128; i++) begin
      v = '{br:1'b0, tgt:8'h00, mreq:1'b0, stalls:0, stray:1'b0, nxt:8'(i + 1)};
      do_instr(v, 8'(i));
    end
    chk("run_done", 32'(if0.done), 32'd1);
    chk("run_fault", 32'(if0.fault), 32'd0);
    chk("run_pc", 32'(if0.prog_ctr), 32'd128);
    chk("run_cnt", 32'(if0.cycle_cnt), 32'd256);
    chk("run_busy", 32'(if0.busy), 32'd0);
    chk("dut1_sat", 32'(if1.cycle_cnt), 32'd15);
    chk("dut1_running", 32'(if1.busy), 32'd1);

    // table: branches, mem stalls, stray inputs, wrap, branch to DONE_ADDR
    do_reset();
    start();
    pc = 8'h00;
    for (int k = 0; k < 14; k++) begin
      do_instr(tab[k], pc);
      pc = tab[k].nxt;
    end
    chk("tab_done", 32'(if0.done), 32'd1);
    chk("tab_pc", 32'(if0.prog_ctr), 32'h80);
    chk("dut1_no_halt", 32'(if1.done), 32'd0);

    // halt is sticky and ignores run
    if0.run = 1'b1;
    cyc();
    if0.run = 1'b0;
    cyc();
    chk("sticky_done", 32'(if0.done), 32'd1);
    chk("sticky_fetch", 32'(if0.fetch), 32'd0);
    chk("sticky_pc", 32'(if0.prog_ctr), 32'h80);

    // mem_ack timeout -> fault
    do_reset();
    start();
    if0.mem_req = 1'b1;
    cyc();
    for (int i = 0; i < 14; i++) begin
      cyc();
      @(negedge clk);
      chk("tmo_waiting", 32'(if0.busy), 32'd1);
      #1;
    end
    cyc();
    clr_in();
    chk("tmo_fault", 32'(if0.fault), 32'd1);
    chk("tmo_done", 32'(if0.done), 32'd0);
    chk("tmo_pc", 32'(if0.prog_ctr), 32'd0);
    chk("tmo_busy", 32'(if0.busy), 32'd0);
    chk("tmo_cnt", 32'(if0.cycle_cnt), 32'd16);

    // reset during WAIT_MEM while ack arrives
    do_reset();
    start();
    if0.mem_req = 1'b1;
    cyc(); cyc();
    rst = 1'b1;
    if0.mem_ack = 1'b1;
    @(negedge clk);
    chk("rstw_no_exec", 32'(if0.exec_en), 32'd0);
    cyc();
    rst = 1'b0;
    clr_in();
    chk("rstw_busy", 32'(if0.busy), 32'd0);
    chk("rstw_pc", 32'(if0.prog_ctr), 32'd0);
    chk("rstw_cnt", 32'(if0.cycle_cnt), 32'd0);

    // reset during a commit cycle, then restart
    start();
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rstc_no_exec", 32'(if0.exec_en), 32'd0);
    cyc();
    rst = 1'b0;
    chk("rstc_pc", 32'(if0.prog_ctr), 32'd0);
    chk("rstc_cnt", 32'(if0.cycle_cnt), 32'd0);
    chk("rstc_fetch", 32'(if0.fetch), 32'd0);
    start();
    v = '{br:1'b0, tgt:8'h00, mreq:1'b0, stalls:0, stray:1'b0, nxt:8'h01};
    do_instr(v, 8'h00);
    @(negedge clk);

    chk("scb_empty", 32'(scb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
